// File: rtl/lane_align_gen.sv
// lane_align_gen: per-lane deskew FIFOs that release one DFI read beat once every enabled lane holds data.
// Define LANE_ALIGN_STATS_EN to build the inter-lane skew statistic on skew_max (tied to 0 otherwise).
module lane_align_gen #(
  parameter int unsigned LANES           = 2,
  parameter int unsigned LANE_DW         = 64,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned BYTE_INTERLEAVE = 1,
  parameter int unsigned TIMEOUT         = 15
) (
  input  logic                     SCLK,
  input  logic                     reset_n,
  input  logic [LANES*LANE_DW-1:0] iog_rddata,
  input  logic [LANES-1:0]         iog_rddata_valid,
  input  logic [LANES-1:0]         lane_block,
  input  logic [LANES-1:0]         lane_enable,
  input  logic                     flush,
  input  logic                     dfi_training_complete,
  output logic [LANES*LANE_DW-1:0] dfi_rddata,
  output logic                     dfi_rddata_valid,
  output logic [LANES-1:0]         ovf_err,
  output logic                     timeout_err,
  output logic [7:0]               skew_max
);
  localparam int unsigned BUS_W = LANES * LANE_DW;
  localparam int unsigned NBYTE = LANE_DW / 8;
  localparam int unsigned DEPTH = (FIFO_DEPTH < 3) ? 3 : FIFO_DEPTH;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = 8;

  typedef enum logic [1:0] {IDLE, PARTIAL, ALIGNED, FLUSHING} state_e;

  // Bus bit offset of byte k of a lane; shared by the input and output mapping.
  function automatic int byte_pos(input int lane, input int k);
    if (BYTE_INTERLEAVE != 0) return 8 * (k * int'(LANES) + lane);
    return lane * int'(LANE_DW) + 8 * k;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [LANE_DW-1:0] mem_q    [LANES][DEPTH];
  logic [LANE_DW-1:0] mem_d    [LANES][DEPTH];
  logic [PW-1:0]      wr_ptr_q [LANES];
  logic [PW-1:0]      wr_ptr_d [LANES];
  logic [PW-1:0]      rd_ptr_q [LANES];
  logic [PW-1:0]      rd_ptr_d [LANES];
  logic [CW-1:0]      cnt_q    [LANES];
  logic [CW-1:0]      cnt_d    [LANES];
  logic [LANES-1:0]   blk_q, blk_d, ovf_q, ovf_d;
  logic               tc_q, tc_d, valid_q, valid_d, to_q, to_d;
  logic [BUS_W-1:0]   rddata_q, rddata_d;
  logic [SW-1:0]      skew_cnt_q, skew_cnt_d;
  state_e             state_q, state_d;
`ifdef LANE_ALIGN_STATS_EN
  logic [SW-1:0]      skew_max_q, skew_max_d;
`endif

  logic               flush_req_c, any_ne_c, all_rdy_c, timeout_c, clear_c, pop_c;
  logic [LANES-1:0]   en_ne_c, push_ok_c, pop_lane_c, ovf_set_c;

  // Readiness, flush/timeout decode and per-lane push/pop qualification.
  always_comb begin
    flush_req_c = flush | (dfi_training_complete & ~tc_q);
    en_ne_c     = '0;
    for (int i = 0; i < int'(LANES); i++) en_ne_c[i] = lane_enable[i] & (cnt_q[i] != '0);
    any_ne_c    = |en_ne_c;
    all_rdy_c   = (|lane_enable) & (en_ne_c == lane_enable);
    timeout_c   = (state_q == PARTIAL) & ~flush_req_c & ~all_rdy_c & any_ne_c &
                  (skew_cnt_q >= SW'(TIMEOUT));
    clear_c     = flush_req_c | timeout_c | (state_q == FLUSHING);
    pop_c       = all_rdy_c & ~clear_c;
    push_ok_c   = '0;
    pop_lane_c  = '0;
    ovf_set_c   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      pop_lane_c[i] = pop_c & lane_enable[i];
      if (iog_rddata_valid[i] & ~blk_q[i] & lane_enable[i] & ~clear_c) begin
        // A full lane still accepts a word when it pops in the same cycle.
        if ((cnt_q[i] == CW'(DEPTH)) & ~pop_lane_c[i]) ovf_set_c[i] = 1'b1;
        else                                           push_ok_c[i] = 1'b1;
      end
    end
  end

  // FIFO storage, pointers and the registered DFI beat.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | ovf_set_c;
    blk_d    = lane_block;
    tc_d     = dfi_training_complete;
    valid_d  = pop_c;
    rddata_d = rddata_q;
    if (pop_c) rddata_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (pop_lane_c[i]) begin
        for (int k = 0; k < int'(NBYTE); k++)
          rddata_d[byte_pos(i, k) +: 8] = mem_q[i][rd_ptr_q[i]][8*k +: 8];
      end
      if (clear_c) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push_ok_c[i]) begin
          for (int k = 0; k < int'(NBYTE); k++)
            mem_d[i][wr_ptr_q[i]][8*k +: 8] = iog_rddata[byte_pos(i, k) +: 8];
          wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
        end
        if (pop_lane_c[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        cnt_d[i] = cnt_q[i] + CW'(push_ok_c[i]) - CW'(pop_lane_c[i]);
      end
    end
  end

  // Alignment FSM; skew_cnt doubles as the PARTIAL timeout counter.
  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    to_d       = to_q | timeout_c;
`ifdef LANE_ALIGN_STATS_EN
    skew_max_d = skew_max_q;
`endif
    if (flush_req_c) begin
      state_d = FLUSHING;
    end else begin
      case (state_q)
        IDLE: begin
          if (all_rdy_c) begin
            state_d    = ALIGNED;
            skew_cnt_d = '0;
          end else if (any_ne_c) begin
            state_d    = PARTIAL;
            skew_cnt_d = SW'(1);
          end
        end
        PARTIAL: begin
          if (all_rdy_c) begin
            state_d = ALIGNED;
`ifdef LANE_ALIGN_STATS_EN
            if (skew_cnt_q > skew_max_q) skew_max_d = skew_cnt_q;
`endif
          end else if (!any_ne_c) begin
            state_d = IDLE;
          end else if (timeout_c) begin
            state_d = FLUSHING;
          end else if (skew_cnt_q != '1) begin
            skew_cnt_d = skew_cnt_q + SW'(1);
          end
        end
        ALIGNED: begin
          if (!all_rdy_c) begin
            if (any_ne_c) begin
              state_d    = PARTIAL;
              skew_cnt_d = SW'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        FLUSHING: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LANES); i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      blk_q      <= '0;
      ovf_q      <= '0;
      tc_q       <= 1'b0;
      valid_q    <= 1'b0;
      to_q       <= 1'b0;
      rddata_q   <= '0;
      skew_cnt_q <= '0;
      state_q    <= IDLE;
`ifdef LANE_ALIGN_STATS_EN
      skew_max_q <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      ovf_q      <= ovf_d;
      tc_q       <= tc_d;
      valid_q    <= valid_d;
      to_q       <= to_d;
      rddata_q   <= rddata_d;
      skew_cnt_q <= skew_cnt_d;
      state_q    <= state_d;
`ifdef LANE_ALIGN_STATS_EN
      skew_max_q <= skew_max_d;
`endif
    end
  end

  // Storage needs no reset: occupancy counts alone decide what is readable.
  always_ff @(posedge SCLK) begin
    mem_q <= mem_d;
  end

  assign dfi_rddata       = rddata_q;
  assign dfi_rddata_valid = valid_q;
  assign ovf_err          = ovf_q;
  assign timeout_err      = to_q;
`ifdef LANE_ALIGN_STATS_EN
  assign skew_max         = skew_max_q;
`else
  assign skew_max         = '0;
`endif

endmodule
